// File: rtl/apb_master.sv
// apb_master: converts a single-outstanding request/response interface into
// APB setup/access transfers, with wait states, PSLVERR and a bounded-wait
// timeout.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   req, req_write,      request valid, direction (1=write), address and
//   req_addr, req_wdata  write data; accepted when req & req_ready
//   req_ready            high only while idle
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata, rsp_err   read data (0 for writes/errors) and error status
//   PSEL, PENABLE,       APB master outputs
//   PWRITE, PADDR, PWDATA
//   PRDATA, PREADY,      APB slave responses, only looked at during ACCESS
//   PSLVERR
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // A zero timeout still needs a 1-bit counter so the width stays legal.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int CNT_SAT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign req_ready = (state == IDLE);

    // The counter holds the number of PREADY=0 cycles already seen; this
    // cycle's stall is the one that reaches the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_MAX - CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wait_cnt  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        PADDR   <= req_addr;
                        PWDATA  <= req_wdata;
                        PWRITE  <= req_write;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                        state     <= IDLE;
                    end else begin
                        if (wait_cnt != CNT_MAX)
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            PSEL      <= 1'b0;
                            PENABLE   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
